// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types, screen limits and sprite ROM contents for the sprite layer.
package sprite_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam int unsigned SCREEN_W        = 640;
    localparam int unsigned SCREEN_H        = 480;
    localparam int unsigned TRANSPARENT_IDX = 0;

    // Texel art: addr = frame*W*H + ty*W + tx; the frame term keeps animation frames distinct.
    function automatic int unsigned rom_texel(input int unsigned addr);
        return (addr + (addr >> 4) + 3 * (addr >> 8) + 1) & 32'hF;
    endfunction

endpackage

// File: rtl/sprite_palette.sv
// rtl/sprite_palette.sv - combinational palette index to rgb444 lookup.
import sprite_pkg::*;

module sprite_palette #(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [11:0]      rgb_o
);

    logic [3:0] i4;
    rgb444_t    c;

    always_comb begin
        i4    = 4'(idx_i);
        c.r   = i4;
        c.g   = ~i4;
        c.b   = {i4[1:0], i4[3:2]};
        rgb_o = c;
    end

endmodule

// File: rtl/sprite_rom.sv
// rtl/sprite_rom.sv - synchronous sprite texel ROM, one palette index per address.
import sprite_pkg::*;

module sprite_rom #(
    parameter int AW    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [AW-1:0]    addr_i,
    output logic [IDX_W-1:0] data_o
);

    logic [IDX_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= IDX_W'(rom_texel(32'(addr_i)));
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/sprite_layer.sv
// rtl/sprite_layer.sv - animated, scaled sprite overlay with a 2-cycle pixel pipeline.
// Optional horizontal mirroring is enabled by defining SPRITE_MIRROR_EN.
import sprite_pkg::*;

module sprite_layer #(
    parameter int SPR_W      = 16,
    parameter int SPR_H      = 16,
    parameter int SCALE_LOG2 = 1,
    parameter int FRAMES     = 4,
    parameter int FRAME_DIV  = 8,
    parameter int IDX_W      = 4
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic [3:0] bg_red,
    input  logic [3:0] bg_green,
    input  logic [3:0] bg_blue,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic       pos_valid,
    output logic       pos_ready,
    input  logic       anim_en,
`ifdef SPRITE_MIRROR_EN
    input  logic       mirror_x,
`endif
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hit
);

    localparam int BOX_W = SPR_W << SCALE_LOG2;
    localparam int BOX_H = SPR_H << SCALE_LOG2;
    localparam int AW    = $clog2(FRAMES * SPR_W * SPR_H);
    localparam int TXW   = $clog2(SPR_W);
    localparam int TYW   = $clog2(SPR_H);
    localparam int FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int CW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [9:0]    act_x_q, act_x_d, act_y_q, act_y_d;
    logic [9:0]    pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] anim_q, anim_d;
`ifdef SPRITE_MIRROR_EN
    logic          mir_q, mir_d, pend_mir_q, pend_mir_d;
`endif
    logic          frame_start, xfer;

    always_comb begin
        act_x_d    = act_x_q;
        act_y_d    = act_y_q;
        pend_x_d   = pend_x_q;
        pend_y_d   = pend_y_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        anim_d     = anim_q;
`ifdef SPRITE_MIRROR_EN
        mir_d      = mir_q;
        pend_mir_d = pend_mir_q;
`endif
        frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
        xfer        = pos_valid && !pend_q;

        if (frame_start && pend_q) begin
            act_x_d = pend_x_q;
            act_y_d = pend_y_q;
            pend_d  = 1'b0;
`ifdef SPRITE_MIRROR_EN
            mir_d   = pend_mir_q;
`endif
        end
        if (frame_start && anim_en) begin
            if (cnt_q == CW'(FRAME_DIV - 1)) begin
                cnt_d  = '0;
                anim_d = (anim_q == FW'(FRAMES - 1)) ? '0 : anim_q + 1'b1;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end
        // A transfer on the frame-start cycle can only happen with pending empty, so it waits a frame.
        if (xfer) begin
            pend_d   = 1'b1;
            pend_x_d = pos_x;
            pend_y_d = pos_y;
`ifdef SPRITE_MIRROR_EN
            pend_mir_d = mirror_x;
`endif
        end
    end

    assign pos_ready = !pend_q;

    // Stage 1 uses next-state position/frame so the frame-start pixel already sees the new values.
    logic [10:0]    off_x, off_y;
    logic           in_box_d;
    logic [TXW-1:0] tx;
    logic [TYW-1:0] ty;
    logic [AW-1:0]  addr_d;

    always_comb begin
        off_x    = {1'b0, DrawX} - {1'b0, act_x_d};
        off_y    = {1'b0, DrawY} - {1'b0, act_y_d};
        in_box_d = (off_x < 11'(BOX_W)) && (off_y < 11'(BOX_H)) &&
                   (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));
        tx       = off_x[SCALE_LOG2 +: TXW];
`ifdef SPRITE_MIRROR_EN
        if (mir_d) begin
            tx = TXW'(SPR_W - 1) - tx;
        end
`endif
        ty       = off_y[SCALE_LOG2 +: TYW];
        addr_d   = AW'(anim_d) * AW'(SPR_W * SPR_H) + AW'(ty) * AW'(SPR_W) + AW'(tx);
    end

    logic [AW-1:0] addr_q;
    logic          in_box1_q, blank1_q, in_box2_q, blank2_q;
    logic [11:0]   bg1_q, bg2_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            act_x_q    <= '0;
            act_y_q    <= '0;
            pend_x_q   <= '0;
            pend_y_q   <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            anim_q     <= '0;
`ifdef SPRITE_MIRROR_EN
            mir_q      <= 1'b0;
            pend_mir_q <= 1'b0;
`endif
            addr_q     <= '0;
            in_box1_q  <= 1'b0;
            blank1_q   <= 1'b0;
            bg1_q      <= '0;
            in_box2_q  <= 1'b0;
            blank2_q   <= 1'b0;
            bg2_q      <= '0;
        end else begin
            act_x_q    <= act_x_d;
            act_y_q    <= act_y_d;
            pend_x_q   <= pend_x_d;
            pend_y_q   <= pend_y_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            anim_q     <= anim_d;
`ifdef SPRITE_MIRROR_EN
            mir_q      <= mir_d;
            pend_mir_q <= pend_mir_d;
`endif
            addr_q     <= addr_d;
            in_box1_q  <= in_box_d;
            blank1_q   <= blank;
            bg1_q      <= {bg_red, bg_green, bg_blue};
            in_box2_q  <= in_box1_q;
            blank2_q   <= blank1_q;
            bg2_q      <= bg1_q;
        end
    end

    logic [IDX_W-1:0] idx;
    logic [11:0]      pal_rgb;

    sprite_rom #(.AW(AW), .IDX_W(IDX_W)) u_rom (
        .clk_i  (vga_clk),
        .rst_ni (reset_n),
        .addr_i (addr_q),
        .data_o (idx)
    );

    sprite_palette #(.IDX_W(IDX_W)) u_palette (
        .idx_i (idx),
        .rgb_o (pal_rgb)
    );

    always_comb begin
        {red, green, blue} = 12'h000;
        hit                = 1'b0;
        if (blank2_q) begin
            if (in_box2_q && (idx != IDX_W'(TRANSPARENT_IDX))) begin
                {red, green, blue} = pal_rgb;
                hit                = 1'b1;
            end else begin
                {red, green, blue} = bg2_q;
            end
        end
    end

endmodule

// File: tb/tb_sprite_layer.sv
// tb/tb_sprite_layer.sv - self-checking bench for sprite_layer (default parameters, mirror disabled).
module tb_sprite_layer;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic [9:0] DrawX, DrawY, pos_x, pos_y;
    logic       blank, pos_valid, pos_ready, anim_en, hit;
    logic [3:0] bg_red, bg_green, bg_blue, red, green, blue;

    always #5 vga_clk = ~vga_clk;

    sprite_layer dut (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank     (blank),
        .bg_red    (bg_red),
        .bg_green  (bg_green),
        .bg_blue   (bg_blue),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .pos_valid (pos_valid),
        .pos_ready (pos_ready),
        .anim_en   (anim_en),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hit       (hit)
    );

    typedef struct { logic [12:0] val; string nm; } exp_t;
    typedef struct { int x; int y; bit b; logic [11:0] bg; logic [11:0] rgb; bit hit; string nm; } vec_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   m_ax, m_ay, m_px, m_py, m_cnt, m_anim;
    bit   m_pend;

    function automatic int texel(int a);
        return (a + a / 16 + 3 * (a / 256) + 1) % 16;
    endfunction

    function automatic logic [11:0] pal(int i);
        return {4'(i), 4'(15 - i), 4'((i % 4) * 4 + i / 4)};
    endfunction

    // Reference pixel: 16x16 sprite, 2x scale, screen 640x480.
    function automatic logic [12:0] model_px(int x, int y, bit b, logic [11:0] bg);
        int idx;
        if (!b) return 13'd0;
        if (x >= 640 || y >= 480 || x < m_ax || y < m_ay || x - m_ax >= 32 || y - m_ay >= 32)
            return {bg, 1'b0};
        idx = texel(m_anim * 256 + ((y - m_ay) / 2) * 16 + (x - m_ax) / 2);
        if (idx == 0) return {bg, 1'b0};
        return {pal(idx), 1'b1};
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(int x, int y, bit b, logic [11:0] bg, bit pv, int px, int py, bit ae,
                       bit use_model, logic [12:0] e, string nm);
        bit   rdy;
        exp_t ent;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        {bg_red, bg_green, bg_blue} = bg;
        pos_valid = pv;
        pos_x = 10'(px);
        pos_y = 10'(py);
        anim_en = ae;
        rdy = !m_pend;
        if (x == 0 && y == 0) begin
            if (m_pend) begin
                m_ax = m_px;
                m_ay = m_py;
                m_pend = 1'b0;
            end
            if (ae) begin
                m_cnt++;
                if (m_cnt == 8) begin
                    m_cnt = 0;
                    m_anim = (m_anim + 1) % 4;
                end
            end
        end
        if (pv && rdy) begin
            m_pend = 1'b1;
            m_px = px;
            m_py = py;
        end
        ent.val = use_model ? model_px(x, y, b, bg) : e;
        ent.nm  = nm;
        expq.push_back(ent);
        @(posedge vga_clk);
        #1;
        if (expq.size() >= 2) begin
            ent = expq.pop_front();
            check(ent.nm, {19'd0, red, green, blue, hit}, {19'd0, ent.val});
        end
        check("pos_ready", 32'(pos_ready), 32'(!m_pend));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_out", {19'd0, red, green, blue, hit}, 32'd0);
        check("rst_ready", 32'(pos_ready), 32'd1);
        @(posedge vga_clk);
        #1;
        check("rst_hold_out", {19'd0, red, green, blue, hit}, 32'd0);
        m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_cnt = 0; m_anim = 0; m_pend = 1'b0;
        expq.delete();
        #2 reset_n = 1'b1;
    endtask

    vec_t        tbl[10];
    logic [11:0] anim_col[4];

    initial begin
        tbl[0] = '{100,  50, 1'b1, 12'h123, 12'h1E4, 1'b1, "origin"};
        tbl[1] = '{ 99,  50, 1'b1, 12'h123, 12'h123, 1'b0, "left_of_box"};
        tbl[2] = '{130,  50, 1'b1, 12'h456, 12'h456, 1'b0, "transparent"};
        tbl[3] = '{131,  81, 1'b1, 12'hABC, 12'hF0F, 1'b1, "bottom_right"};
        tbl[4] = '{132,  50, 1'b1, 12'h789, 12'h789, 1'b0, "right_of_box"};
        tbl[5] = '{100,  82, 1'b1, 12'h321, 12'h321, 1'b0, "below_box"};
        tbl[6] = '{102,  52, 1'b1, 12'h555, 12'h3CC, 1'b1, "texel_1_1"};
        tbl[7] = '{100,  50, 1'b0, 12'h777, 12'h000, 1'b0, "blank_in_box"};
        tbl[8] = '{101,  51, 1'b1, 12'h111, 12'h1E4, 1'b1, "same_texel"};
        tbl[9] = '{116,  50, 1'b1, 12'h222, 12'h966, 1'b1, "texel_8_0"};
        anim_col[0] = 12'h1E4;
        anim_col[1] = 12'h4B1;
        anim_col[2] = 12'h78D;
        anim_col[3] = 12'hA5A;

        reset_n = 1'b1;
        DrawX = '0; DrawY = '0; blank = 1'b0; pos_x = '0; pos_y = '0;
        pos_valid = 1'b0; anim_en = 1'b0;
        {bg_red, bg_green, bg_blue} = 12'h000;
        #2;
        do_reset();

        cyc(300, 10, 1, 12'h000, 1, 100, 50, 0, 1, 13'd0, "setup_xfer");
        cyc(0, 0, 1, 12'h000, 0, 0, 0, 0, 1, 13'd0, "setup_fs");
        for (int i = 0; i < 10; i++)
            cyc(tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].bg, 0, 0, 0, 0, 0, {tbl[i].rgb, tbl[i].hit}, tbl[i].nm);

        // Mid-frame position update is held until the next frame start.
        cyc(300, 10, 1, 12'h0AA, 1, 200, 200, 0, 1, 13'd0, "mid_xfer");
        check("ready_dropped", 32'(pos_ready), 32'd0);
        cyc(100, 50, 1, 12'h0AA, 1, 400, 400, 0, 0, {12'h1E4, 1'b1}, "old_pos_held");
        cyc(200, 200, 1, 12'h0BB, 0, 0, 0, 0, 0, {12'h0BB, 1'b0}, "new_pos_not_yet");
        cyc(0, 0, 1, 12'h000, 0, 0, 0, 0, 1, 13'd0, "fs_apply");
        cyc(200, 200, 1, 12'h0CC, 0, 0, 0, 0, 0, {12'h1E4, 1'b1}, "new_pos_applied");
        check("ready_restored", 32'(pos_ready), 32'd1);
        cyc(100, 50, 1, 12'h0DD, 0, 0, 0, 0, 0, {12'h0DD, 1'b0}, "old_pos_gone");

        // Transfer on the frame-start cycle, then edge clipping.
        cyc(0, 0, 1, 12'h000, 1, 630, 470, 0, 1, 13'd0, "fs_xfer");
        cyc(630, 470, 1, 12'h111, 0, 0, 0, 0, 0, {12'h111, 1'b0}, "xfer_not_applied");
        cyc(0, 0, 1, 12'h000, 0, 0, 0, 0, 1, 13'd0, "fs_apply2");
        cyc(630, 470, 1, 12'h222, 0, 0, 0, 0, 0, {12'h1E4, 1'b1}, "clip_origin");
        cyc(639, 479, 1, 12'h333, 0, 0, 0, 0, 0, {12'h966, 1'b1}, "clip_corner");
        cyc(640, 470, 1, 12'h444, 0, 0, 0, 0, 0, {12'h444, 1'b0}, "clip_x");
        cyc(0, 470, 1, 12'h555, 0, 0, 0, 0, 0, {12'h555, 1'b0}, "no_wrap_x");
        cyc(639, 480, 1, 12'h666, 0, 0, 0, 0, 0, {12'h666, 1'b0}, "clip_y");
        cyc(5, 5, 1, 12'h000, 0, 0, 0, 0, 1, 13'd0, "flush");

        // Reset mid-frame with a pending update.
        cyc(300, 10, 1, 12'h000, 1, 300, 300, 0, 1, 13'd0, "pre_rst_xfer");
        cyc(301, 10, 1, 12'h000, 0, 0, 0, 0, 1, 13'd0, "pre_rst");
        cyc(302, 10, 1, 12'h000, 0, 0, 0, 0, 1, 13'd0, "pre_rst_flush");
        do_reset();
        cyc(2, 2, 1, 12'h0EE, 0, 0, 0, 0, 0, {12'h3CC, 1'b1}, "post_rst_pos0");
        cyc(0, 0, 1, 12'h000, 0, 0, 0, 0, 1, 13'd0, "post_rst_fs");
        cyc(300, 300, 1, 12'h0F0, 0, 0, 0, 0, 0, {12'h0F0, 1'b0}, "pending_discarded");

        // Animation: one step every 8 enabled frame starts, wrapping after 4 frames.
        for (int k = 1; k <= 40; k++) begin
            cyc(0, 0, 1, 12'h000, 0, 0, 0, 1, 1, 13'd0, "anim_fs");
            cyc(1, 1, 1, 12'h0A0, 0, 0, 0, 1, 0, {anim_col[(k / 8) % 4], 1'b1}, $sformatf("anim_%0d", k));
        end
        for (int k = 0; k < 10; k++)
            cyc(0, 0, 1, 12'h000, 0, 0, 0, 0, 1, 13'd0, "hold_fs");
        cyc(1, 1, 1, 12'h0A0, 0, 0, 0, 0, 0, {12'h4B1, 1'b1}, "anim_hold");

        for (int n = 0; n < 3000; n++) begin
            int          x, y, px, py, r;
            bit          b, pv, ae;
            logic [11:0] bg;
            r = int'($urandom_range(0, 63));
            if (r == 0) begin
                x = 0; y = 0;
            end else if (r < 16) begin
                x = int'($urandom_range(0, 799));
                y = int'($urandom_range(0, 524));
            end else begin
                x = m_ax + int'($urandom_range(0, 40)) - 4;
                y = m_ay + int'($urandom_range(0, 40)) - 4;
            end
            if (x < 0) x = 0;
            if (x > 799) x = 799;
            if (y < 0) y = 0;
            if (y > 524) y = 524;
            b  = ($urandom_range(0, 7) != 0);
            pv = ($urandom_range(0, 9) == 0);
            px = int'($urandom_range(0, 680));
            py = int'($urandom_range(0, 520));
            ae = 1'($urandom_range(0, 1));
            bg = 12'($urandom);
            cyc(x, y, b, bg, pv, px, py, ae, 1, 13'd0, "random");
        end
        cyc(5, 5, 1, 12'h000, 0, 0, 0, 0, 1, 13'd0, "final_flush");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
